// File: rtl/cn_u.sv
// ----------------------------------------------------------------------------
// Module   : cn_u
// Brief    : Check-node update/compress unit: min0, min1, idx of min0 and sign total per row.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module cn_u #(
  parameter int MSG_WIDTH   = 6,
  parameter int COL_CNT_WID = 7,
  parameter int ABS_WID     = MSG_WIDTH - 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [MSG_WIDTH-1:0]   i_v2c,
  input  logic                   i_v2c_vld,
  input  logic                   i_first,
  input  logic                   i_last,
  output logic [ABS_WID-1:0]     o_v2c_abs_0,
  output logic [ABS_WID-1:0]     o_v2c_abs_1,
  output logic [COL_CNT_WID-1:0] o_idx_0,
  output logic                   o_v2c_sign_tot,
  output logic                   o_row_vld,
  output logic                   o_v2c_sign,
  output logic [COL_CNT_WID-1:0] o_sign_col,
  output logic                   o_sign_vld,
  output logic                   o_ovf
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [ABS_WID-1:0]     min0_q, min0_d, min1_q, min1_d;
  logic [COL_CNT_WID-1:0] idx_q, idx_d, col_q, col_d;
  logic                   stot_q, stot_d, ovf_q, ovf_d;
  logic [ABS_WID-1:0]     res_abs0_q, res_abs0_d, res_abs1_q, res_abs1_d;
  logic [COL_CNT_WID-1:0] res_idx_q, res_idx_d, sign_col_q, sign_col_d;
  logic                   res_tot_q, res_tot_d, row_vld_q, row_vld_d;
  logic                   sign_q, sign_d, sign_vld_q, sign_vld_d;

  logic                   w_sign;
  logic [MSG_WIDTH-1:0]   w_neg;
  logic [ABS_WID-1:0]     w_abs;
  logic                   w_seed, w_upd;
  logic [COL_CNT_WID-1:0] w_beat_col;

  assign w_sign = i_v2c[MSG_WIDTH-1];
  assign w_neg  = -i_v2c;
  assign w_seed = i_v2c_vld && i_first;
  assign w_upd  = i_v2c_vld && !i_first && (state_q == ACC);
  assign w_beat_col = w_seed ? '0 : col_q;

  // Negating the most negative code wraps back to a negative value; saturate it.
  always_comb begin
    w_abs = i_v2c[ABS_WID-1:0];
    if (w_sign) begin
      if (w_neg[MSG_WIDTH-1]) w_abs = '1;
      else                    w_abs = w_neg[ABS_WID-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    min0_d     = min0_q;
    min1_d     = min1_q;
    idx_d      = idx_q;
    col_d      = col_q;
    stot_d     = stot_q;
    ovf_d      = ovf_q;
    res_abs0_d = res_abs0_q;
    res_abs1_d = res_abs1_q;
    res_idx_d  = res_idx_q;
    res_tot_d  = res_tot_q;
    row_vld_d  = 1'b0;
    sign_d     = sign_q;
    sign_col_d = sign_col_q;
    sign_vld_d = 1'b0;

    if (w_seed) begin
      state_d = ACC;
      min0_d  = w_abs;
      min1_d  = '1;
      idx_d   = '0;
      stot_d  = w_sign;
      col_d   = COL_CNT_WID'(1);
      ovf_d   = 1'b0;
    end else if (w_upd) begin
      if (w_abs < min0_q) begin
        min1_d = min0_q;
        min0_d = w_abs;
        idx_d  = col_q;
      end else if (w_abs < min1_q) begin
        min1_d = w_abs;
      end
      stot_d = stot_q ^ w_sign;
      // Counter saturates at its top code; overflow only matters if the row stays open.
      if (col_q == '1) begin
        if (!i_last) ovf_d = 1'b1;
      end else begin
        col_d = col_q + COL_CNT_WID'(1);
      end
    end

    if (w_seed || w_upd) begin
      sign_vld_d = 1'b1;
      sign_d     = w_sign;
      sign_col_d = w_beat_col;
      if (i_last) begin
        state_d    = IDLE;
        res_abs0_d = min0_d;
        res_abs1_d = min1_d;
        res_idx_d  = idx_d;
        res_tot_d  = stot_d;
        row_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      min0_q     <= '0;
      min1_q     <= '0;
      idx_q      <= '0;
      col_q      <= '0;
      stot_q     <= 1'b0;
      ovf_q      <= 1'b0;
      res_abs0_q <= '1;
      res_abs1_q <= '1;
      res_idx_q  <= '0;
      res_tot_q  <= 1'b0;
      row_vld_q  <= 1'b0;
      sign_q     <= 1'b0;
      sign_col_q <= '0;
      sign_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min0_q     <= min0_d;
      min1_q     <= min1_d;
      idx_q      <= idx_d;
      col_q      <= col_d;
      stot_q     <= stot_d;
      ovf_q      <= ovf_d;
      res_abs0_q <= res_abs0_d;
      res_abs1_q <= res_abs1_d;
      res_idx_q  <= res_idx_d;
      res_tot_q  <= res_tot_d;
      row_vld_q  <= row_vld_d;
      sign_q     <= sign_d;
      sign_col_q <= sign_col_d;
      sign_vld_q <= sign_vld_d;
    end
  end

  assign o_v2c_abs_0    = res_abs0_q;
  assign o_v2c_abs_1    = res_abs1_q;
  assign o_idx_0        = res_idx_q;
  assign o_v2c_sign_tot = res_tot_q;
  assign o_row_vld      = row_vld_q;
  assign o_v2c_sign     = sign_q;
  assign o_sign_col     = sign_col_q;
  assign o_sign_vld     = sign_vld_q;
  assign o_ovf          = ovf_q;

endmodule

`default_nettype wire
